// File: rtl/rv32_enc_pkg.sv
// Shared RV32I opcode constants and format classification, used by both the
// encoder (program-loader path) and the decode side.
package rv32_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_to_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:             f = FMT_R;
            OP_LOAD, OP_ALUI: f = FMT_I;
            OP_STORE:         f = FMT_S;
            OP_BRANCH:        f = FMT_B;
            OP_JAL:           f = FMT_J;
            default:          f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO holding encoded instruction words; the head is
// visible combinationally and reads as zero while the FIFO is empty.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    // Storage carries no reset so it can map onto plain RAM; validity comes from count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I fields into instruction words, buffers them and streams them to
// the IMEM write port at an auto-incrementing byte address.
module inst_encoder
    import rv32_enc_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_clr,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    fmt_e              fmt;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] addr_reg;
    logic              err_pulse_reg;
    logic [7:0]        err_count_reg;

    // Immediate packing mirrors the core's extraction; the range checks make
    // sure the discarded upper bits are pure sign extension.
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        fmt      = opcode_to_fmt(opcode);
        case (fmt)
            FMT_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
                enc_ok   = 1'b1;
            end
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                enc_ok   = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_ok   = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_ok   = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_ok   = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    assign in_ready = ~full;
    assign accept   = in_valid & in_ready;
    assign push     = accept & enc_ok;
    assign mem_we   = ~empty;
    assign pop      = mem_we & mem_ready;

    enc_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(enc_word),
        .head (mem_wdata),
        .full (full),
        .empty(empty)
    );

    // addr_clr wins over the increment: a word popped on the same edge has
    // already been written at the old address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_reg      <= BASE_ADDR;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            err_pulse_reg <= accept & ~enc_ok;
            if (accept && !enc_ok && err_count_reg != 8'hFF) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
            if (addr_clr) begin
                addr_reg <= BASE_ADDR;
            end else if (pop) begin
                addr_reg <= addr_reg + ADDR_W'(4);
            end
        end
    end

    assign mem_addr  = addr_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;

endmodule
